// File: rtl/mul_issue_sched.sv
// Issue scheduler for a shared, non-pipelined, fixed-latency multiplier FU.
// Round-robin accepts one RS op, launches it, tracks it through the FU and holds the result for the CDB.
module mul_issue_sched #(
    parameter int unsigned N    = 4,
    parameter int unsigned TAGW = 5,
    parameter int unsigned LAT  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [N-1:0]      req_i,
    input  logic [N*32-1:0]   req_a_i,
    input  logic [N*32-1:0]   req_b_i,
    input  logic [N*TAGW-1:0] req_tag_i,
    output logic [N-1:0]      gnt_o,
    output logic              fu_en_o,
    output logic [31:0]       fu_a_o,
    output logic [31:0]       fu_b_o,
    input  logic [31:0]       fu_res_i,
    output logic              cdb_req_o,
    output logic [TAGW-1:0]   cdb_tag_o,
    output logic [31:0]       cdb_data_o,
    input  logic              cdb_gnt_i,
    output logic              busy_o
);

    localparam int unsigned DW   = 32;
    localparam int unsigned PTRW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNTW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              squash_q, squash_d;
    logic              fu_en_q, fu_en_d;
    logic [DW-1:0]     fu_a_q, fu_a_d;
    logic [DW-1:0]     fu_b_q, fu_b_d;
    logic              cdb_req_q, cdb_req_d;
    logic [TAGW-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DW-1:0]     cdb_data_q, cdb_data_d;

    logic              win_found;
    logic [PTRW-1:0]   win_idx;
    logic [PTRW-1:0]   cand;
    logic [DW-1:0]     sel_a, sel_b;
    logic [TAGW-1:0]   sel_tag;

    // Round-robin search starting just after the last winner, plus the winner's operand mux.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_tag   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = PTRW'((32'(rr_ptr_q) + k) % N);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (win_idx == PTRW'(i)) begin
                sel_a   = req_a_i[i*DW +: DW];
                sel_b   = req_b_i[i*DW +: DW];
                sel_tag = req_tag_i[i*TAGW +: TAGW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        squash_d   = squash_q;
        fu_en_d    = 1'b0;
        fu_a_d     = fu_a_q;
        fu_b_d     = fu_b_q;
        cdb_req_d  = cdb_req_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        gnt_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found && !flush_i) begin
                    gnt_o[win_idx] = 1'b1;
                    fu_a_d         = sel_a;
                    fu_b_d         = sel_b;
                    cdb_tag_d      = sel_tag;
                    rr_ptr_d       = win_idx;
                    fu_en_d        = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The FU is already launched, so a flush here can only mark the result for discard.
                cnt_d   = CNTW'(LAT - 1);
                state_d = S_WAIT;
                if (flush_i) begin
                    squash_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (flush_i) begin
                        squash_d = 1'b1;
                    end
                end else if (squash_q || flush_i) begin
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cdb_data_d = fu_res_i;
                    cdb_req_d  = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_i || cdb_gnt_i) begin
                    cdb_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= PTRW'(N - 1);
            cnt_q      <= '0;
            squash_q   <= 1'b0;
            fu_en_q    <= 1'b0;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            cdb_req_q  <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            squash_q   <= squash_d;
            fu_en_q    <= fu_en_d;
            fu_a_q     <= fu_a_d;
            fu_b_q     <= fu_b_d;
            cdb_req_q  <= cdb_req_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
        end
    end

    assign fu_en_o    = fu_en_q;
    assign fu_a_o     = fu_a_q;
    assign fu_b_o     = fu_b_q;
    assign cdb_req_o  = cdb_req_q;
    assign cdb_tag_o  = cdb_tag_q;
    assign cdb_data_o = cdb_data_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule
